program_loader: RTL and testbench

Byte-stream loader that writes a program image into the instruction memory read by the single-cycle RISC-V core. It accepts a framed image (length, little-endian words, XOR checksum) over a valid/ready byte interface and emits one 32-bit write per assembled word. It holds the core in reset until the image is accepted.

---
 rtl/program_loader.sv | 145 ++++++++++++++
 tb/tb_program_loader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader: receives a framed program image over a valid/ready byte
// stream and writes each assembled 32-bit word into instruction memory.
// Frame layout: LEN_LO, LEN_HI (word count N), 4N data bytes with each word
// LSB first, then CSUM (XOR of the data bytes only). The core is held in
// reset until a complete image with a matching checksum has been accepted.
//
// Handshake: a byte transfers on a rising edge where Byte_Valid_i and
// Byte_Ready_o are both high. Byte_Ready_o stays high for the whole frame and
// drops only in DONE or ERROR. Idle cycles on Byte_Valid_i change nothing.
module program_loader #(
    parameter int          MEMORY_DEPTH = 64,
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  Byte_i,
    input  logic        Byte_Valid_i,
    output logic        Byte_Ready_o,
    input  logic        Reload_i,
    output logic        Prog_We_o,
    output logic [31:0] Prog_Address_o,
    output logic [31:0] Prog_Data_o,
    output logic        Core_Hold_o,
    output logic        Done_o,
    output logic        Error_o,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_LEN_LO = 3'd0,
        S_LEN_HI = 3'd1,
        S_DATA   = 3'd2,
        S_CSUM   = 3'd3,
        S_DONE   = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

    localparam logic [15:0] DEPTH_WORDS = 16'(MEMORY_DEPTH);

    state_t      state;
    logic [7:0]  len_lo;
    logic [15:0] word_count;
    logic [15:0] word_index;
    logic [1:0]  lane;
    logic [7:0]  csum;
    logic [23:0] word_buf;     // lanes 0..2 of the word being assembled

    logic        accept;
    logic [15:0] frame_len;

    assign accept    = Byte_Valid_i & Byte_Ready_o;
    assign frame_len = {Byte_i, len_lo};
    assign state_dbg = state;

    // Frame parser FSM; all outputs are registered here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_LEN_LO;
            len_lo         <= 8'd0;
            word_count     <= 16'd0;
            word_index     <= 16'd0;
            lane           <= 2'd0;
            csum           <= 8'd0;
            word_buf       <= 24'd0;
            Byte_Ready_o   <= 1'b1;
            Prog_We_o      <= 1'b0;
            Prog_Address_o <= BASE_ADDRESS;
            Prog_Data_o    <= 32'd0;
            Core_Hold_o    <= 1'b1;
            Done_o         <= 1'b0;
            Error_o        <= 1'b0;
        end else begin
            // Write strobe is a single-cycle pulse; address/data hold.
            Prog_We_o <= 1'b0;
            case (state)
                S_LEN_LO: begin
                    if (accept) begin
                        len_lo <= Byte_i;
                        state  <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (accept) begin
                        word_count <= frame_len;
                        if (frame_len == 16'd0 || frame_len > DEPTH_WORDS) begin
                            state        <= S_ERROR;
                            Error_o      <= 1'b1;
                            Byte_Ready_o <= 1'b0;
                        end else begin
                            state      <= S_DATA;
                            word_index <= 16'd0;
                            lane       <= 2'd0;
                            csum       <= 8'd0;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        csum <= csum ^ Byte_i;
                        lane <= lane + 2'd1;
                        if (lane == 2'd3) begin
                            // Lane 3 completes the word: {b3, b2, b1, b0}.
                            Prog_We_o      <= 1'b1;
                            Prog_Data_o    <= {Byte_i, word_buf};
                            Prog_Address_o <= BASE_ADDRESS + {14'd0, word_index, 2'b00};
                            word_index     <= word_index + 16'd1;
                            if (word_index == word_count - 16'd1) begin
                                state <= S_CSUM;
                            end
                        end else begin
                            // Shift right so byte k ends up in bits 8k+7:8k.
                            word_buf <= {Byte_i, word_buf[23:8]};
                        end
                    end
                end
                S_CSUM: begin
                    if (accept) begin
                        Byte_Ready_o <= 1'b0;
                        if (Byte_i == csum) begin
                            state       <= S_DONE;
                            Done_o      <= 1'b1;
                            Core_Hold_o <= 1'b0;
                        end else begin
                            state   <= S_ERROR;
                            Error_o <= 1'b1;
                        end
                    end
                end
                S_DONE, S_ERROR: begin
                    if (Reload_i) begin
                        state        <= S_LEN_LO;
                        Byte_Ready_o <= 1'b1;
                        Core_Hold_o  <= 1'b1;
                        Done_o       <= 1'b0;
                        Error_o      <= 1'b0;
                    end
                end
                default: begin
                    state <= S_LEN_LO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed frames driven through a byte driver,
// expected memory writes queued as {address, data} and checked by a monitor.
module tb_program_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic [7:0]  Byte_i;
    logic        Byte_Valid_i;
    logic        Byte_Ready_o;
    logic        Reload_i;
    logic        Prog_We_o;
    logic [31:0] Prog_Address_o;
    logic [31:0] Prog_Data_o;
    logic        Core_Hold_o;
    logic        Done_o;
    logic        Error_o;
    logic [2:0]  state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] exp_q[$];
    logic [31:0] img[0:79];

    program_loader #(.MEMORY_DEPTH(64), .BASE_ADDRESS(BASE)) dut (
        .clk            (clk),
        .reset          (reset),
        .Byte_i         (Byte_i),
        .Byte_Valid_i   (Byte_Valid_i),
        .Byte_Ready_o   (Byte_Ready_o),
        .Reload_i       (Reload_i),
        .Prog_We_o      (Prog_We_o),
        .Prog_Address_o (Prog_Address_o),
        .Prog_Data_o    (Prog_Data_o),
        .Core_Hold_o    (Core_Hold_o),
        .Done_o         (Done_o),
        .Error_o        (Error_o),
        .state_dbg      (state_dbg)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (Prog_We_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", Prog_Address_o, Prog_Data_o);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("write_addr", Prog_Address_o, e[63:32]);
                check("write_data", Prog_Data_o, e[31:0]);
            end
        end
    end

    // Driver: called at a negedge; presents a byte and returns at the next
    // negedge after it was accepted.
    task automatic send_byte(input logic [7:0] b, input logic rl);
        int t;
        t = 0;
        while (Byte_Ready_o !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (Byte_Ready_o !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: got ready %b expected 1", Byte_Ready_o);
        end
        Byte_i       = b;
        Byte_Valid_i = 1'b1;
        Reload_i     = rl;
        @(negedge clk);
        Byte_Valid_i = 1'b0;
        Reload_i     = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends a full frame of n words from img[]; queues the expected writes.
    task automatic send_frame(input int n, input logic [7:0] cs, input int max_gap, input logic rl_mid);
        logic [15:0] len;
        logic [31:0] w;
        len = 16'(n);
        send_byte(len[7:0], 1'b0);
        send_byte(len[15:8], 1'b0);
        for (int i = 0; i < n; i++) begin
            w = img[i];
            exp_q.push_back({BASE + 32'(i) * 32'd4, w});
            for (int k = 0; k < 4; k++) begin
                idle($urandom_range(0, max_gap));
                send_byte(w[8*k +: 8], rl_mid && i == 0 && k == 1);
            end
        end
        idle($urandom_range(0, max_gap));
        send_byte(cs, 1'b0);
    endtask

    task automatic pulse_reload();
        Reload_i = 1'b1;
        @(negedge clk);
        Reload_i = 1'b0;
    endtask

    task automatic check_flags(input string tag, input logic done, input logic err,
                               input logic hold, input logic rdy);
        check({tag, "_done"},  {31'd0, Done_o},       {31'd0, done});
        check({tag, "_error"}, {31'd0, Error_o},      {31'd0, err});
        check({tag, "_hold"},  {31'd0, Core_Hold_o},  {31'd0, hold});
        check({tag, "_ready"}, {31'd0, Byte_Ready_o}, {31'd0, rdy});
    endtask

    task automatic check_reset_values(input string tag);
        check_flags(tag, 1'b0, 1'b0, 1'b1, 1'b1);
        check({tag, "_we"},   {31'd0, Prog_We_o}, 32'd0);
        check({tag, "_addr"}, Prog_Address_o, BASE);
        check({tag, "_data"}, Prog_Data_o, 32'd0);
    endtask

    task automatic check_drained(input string tag);
        idle(2);
        check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    endtask

    function automatic logic [7:0] xor_bytes(input int n);
        logic [7:0] c;
        c = 8'd0;
        for (int i = 0; i < n; i++) begin
            c = c ^ img[i][7:0] ^ img[i][15:8] ^ img[i][23:16] ^ img[i][31:24];
        end
        return c;
    endfunction

    task automatic load_nominal();
        img[0] = 32'h0050_0093;
        img[1] = 32'h0000_0013;
    endtask

    // Main sequence
    initial begin
        reset        = 1'b0;
        Byte_i       = 8'd0;
        Byte_Valid_i = 1'b0;
        Reload_i     = 1'b0;
        idle(3);
        check_reset_values("reset");
        reset = 1'b1;
        idle(2);
        check_reset_values("idle_after_reset");

        // Nominal: bytes 93 00 50 00 13 00 00 00 XOR to D0.
        load_nominal();
        send_frame(2, 8'hD0, 0, 1'b0);
        check_flags("nominal", 1'b1, 1'b0, 1'b0, 1'b0);
        check_drained("nominal");

        // Reload from DONE.
        pulse_reload();
        check_flags("reload_done", 1'b0, 1'b0, 1'b1, 1'b1);

        // Bad checksum: both writes still occur.
        send_frame(2, 8'h00, 0, 1'b0);
        check_flags("bad_csum", 1'b0, 1'b1, 1'b1, 1'b0);
        check_drained("bad_csum");
        pulse_reload();
        check_flags("reload_err", 1'b0, 1'b0, 1'b1, 1'b1);

        // N = 0.
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        check_flags("len_zero", 1'b0, 1'b1, 1'b1, 1'b0);
        check_drained("len_zero");
        pulse_reload();

        // N = 65 exceeds depth 64.
        send_byte(8'h41, 1'b0);
        send_byte(8'h00, 1'b0);
        check_flags("len_65", 1'b0, 1'b1, 1'b1, 1'b0);
        check_drained("len_65");
        pulse_reload();

        // N = 64, full memory; last write lands at 0xFC.
        for (int i = 0; i < 64; i++) img[i] = 32'h1000_0000 + 32'(i) * 32'h0102_0305;
        send_frame(64, xor_bytes(64), 0, 1'b0);
        check_flags("len_64", 1'b1, 1'b0, 1'b0, 1'b0);
        check("len_64_last_addr", Prog_Address_o, BASE + 32'h0000_00FC);
        check_drained("len_64");
        pulse_reload();

        // Nominal with random idle gaps between bytes.
        load_nominal();
        send_frame(2, 8'hD0, 3, 1'b0);
        check_flags("gaps", 1'b1, 1'b0, 1'b0, 1'b0);
        check_drained("gaps");
        pulse_reload();

        // N=1 DEADBEEF (EF^BE^AD^DE = 22) with Reload_i pulsed mid-frame.
        img[0] = 32'hDEAD_BEEF;
        send_frame(1, 8'h22, 0, 1'b1);
        check_flags("reload_mid", 1'b1, 1'b0, 1'b0, 1'b0);
        check_drained("reload_mid");
        pulse_reload();

        // Reset after 5 data bytes: first word is written, then abort.
        load_nominal();
        exp_q.push_back({BASE, img[0]});
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h93, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h50, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h13, 1'b0);
        #2 reset = 1'b0;
        #1 check_reset_values("async_reset");
        check("async_reset_state", {29'd0, state_dbg}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        check_drained("reset_mid");
        send_frame(2, 8'hD0, 0, 1'b0);
        check_flags("after_reset", 1'b1, 1'b0, 1'b0, 1'b0);
        check_drained("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
